// File: rtl/soc_reset_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : soc_reset_tick_gen
// Brief    : Staggered per-channel reset sequencer with programmable ticks.
// Revision : 1.0
// ============================================================================
module soc_reset_tick_gen #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int CNT_W       = 8,
  parameter int DIV_W       = 16,
  parameter int DIV_RESET   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst_req,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] rst_out,
  output logic [NUM_CH-1:0] tick,
  output logic              ready
);

  localparam logic [1:0]       ST_ASSERT  = 2'd0;
  localparam logic [1:0]       ST_RELEASE = 2'd1;
  localparam logic [1:0]       ST_RUN     = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST  = CNT_W'(STAGGER - 1);
  localparam logic [3:0]       LAST_CH    = 4'(NUM_CH - 1);
  localparam logic [DIV_W-1:0] DIV_INIT   = DIV_W'(DIV_RESET);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        ch_idx_q, ch_idx_d;
  logic [NUM_CH-1:0] rst_out_q, rst_out_d;
  logic              ready_q, ready_d;
  logic              rel_valid;
  logic [3:0]        rel_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ASSERT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ASSERT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // The last channel's release edge enters RUN directly, so ready
        // follows one cycle after the final channel comes out of reset.
        if ((cnt_q == STAG_LAST) && (ch_idx_q == LAST_CH - 4'd1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase
    if (soft_rst_req) begin
      state_d = ST_ASSERT;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    ch_idx_d  = ch_idx_q;
    rst_out_d = rst_out_q;
    ready_d   = (state_q == ST_RUN);
    rel_valid = 1'b0;
    rel_idx   = 4'd0;
    case (state_q)
      ST_ASSERT: begin
        rst_out_d = '1;
        if (cnt_q == HOLD_LAST) begin
          cnt_d     = '0;
          ch_idx_d  = 4'd0;
          rel_valid = 1'b1;
          rel_idx   = 4'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == STAG_LAST) begin
          cnt_d     = '0;
          ch_idx_d  = ch_idx_q + 4'd1;
          rel_valid = 1'b1;
          rel_idx   = ch_idx_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        cnt_d     = '0;
        rst_out_d = '0;
      end
      default: begin
        cnt_d     = '0;
        ch_idx_d  = 4'd0;
        rst_out_d = '1;
        ready_d   = 1'b0;
      end
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (rel_valid && (rel_idx == 4'(i))) begin
        rst_out_d[i] = 1'b0;
      end
    end
    if (soft_rst_req) begin
      cnt_d     = '0;
      ch_idx_d  = 4'd0;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      ch_idx_q  <= 4'd0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ch_idx_q  <= ch_idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  assign rst_out = rst_out_q;
  assign ready   = ready_q;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] div_q, div_d;
      logic [DIV_W-1:0] tcnt_q, tcnt_d;
      logic             tick_q, tick_d;
      logic             wr;

      assign wr = cfg_we && (cfg_ch == 4'(gi));

      // A write restarts the period so the new divider takes effect cleanly.
      always_comb begin
        div_d  = div_q;
        tcnt_d = tcnt_q;
        tick_d = 1'b0;
        if (wr) begin
          div_d = cfg_div;
        end
        if (soft_rst_req || wr || rst_out_q[gi]) begin
          tcnt_d = '0;
        end else if (tcnt_q == div_q) begin
          tick_d = 1'b1;
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          div_q  <= DIV_INIT;
          tcnt_q <= '0;
          tick_q <= 1'b0;
        end else begin
          div_q  <= div_d;
          tcnt_q <= tcnt_d;
          tick_q <= tick_d;
        end
      end

      assign tick[gi] = tick_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_soc_reset_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_reset_tick_gen
// Brief    : Self-checking bench for soc_reset_tick_gen with a timeline model.
// Revision : 1.0
// ============================================================================
module tb_soc_reset_tick_gen;

  localparam int NUM_CH      = 4;
  localparam int HOLD_CYCLES = 16;
  localparam int STAGGER     = 4;
  localparam int CNT_W       = 8;
  localparam int DIV_W       = 16;
  localparam int DIV_RESET   = 0;
  localparam int READY_AT    = HOLD_CYCLES + (NUM_CH - 1) * STAGGER + 1;

  logic              clk;
  logic              rst;
  logic              soft_rst_req;
  logic              cfg_we;
  logic [3:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] rst_out;
  logic [NUM_CH-1:0] tick;
  logic              ready;

  int checks;
  int failures;

  // Model: k = cycles since the sequence (re)started, age = cycles since a
  // channel's tick phase was restarted (release, write or reset).
  int                k;
  int                age  [NUM_CH];
  int                divm [NUM_CH];
  logic [NUM_CH-1:0] exp_rst;
  logic [NUM_CH-1:0] exp_tick;
  logic              exp_ready;

  soc_reset_tick_gen #(
    .NUM_CH      (NUM_CH),
    .HOLD_CYCLES (HOLD_CYCLES),
    .STAGGER     (STAGGER),
    .CNT_W       (CNT_W),
    .DIV_W       (DIV_W),
    .DIV_RESET   (DIV_RESET)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_div      (cfg_div),
    .rst_out      (rst_out),
    .tick         (tick),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      age[i]  = 0;
      divm[i] = DIV_RESET;
    end
    exp_rst   = '1;
    exp_tick  = '0;
    exp_ready = 1'b0;
  endtask

  task automatic model_edge();
    logic [NUM_CH-1:0] rst_old;
    logic              wr;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NUM_CH; i++) rst_old[i] = (k < HOLD_CYCLES + i * STAGGER);
    if (soft_rst_req) k = 0;
    else if (k < 1000000) k = k + 1;
    for (int i = 0; i < NUM_CH; i++) begin
      wr = cfg_we && (int'(cfg_ch) == i);
      if (wr) divm[i] = int'(cfg_div);
      if (soft_rst_req || wr || rst_old[i]) begin
        age[i]      = 0;
        exp_tick[i] = 1'b0;
      end else begin
        age[i]      = age[i] + 1;
        exp_tick[i] = ((age[i] % (divm[i] + 1)) == 0);
      end
      exp_rst[i] = (k < HOLD_CYCLES + i * STAGGER);
    end
    exp_ready = (k >= READY_AT);
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".rst_out"}, 32'(rst_out), 32'(exp_rst));
    check({ctx, ".tick"},    32'(tick),    32'(exp_tick));
    check({ctx, ".ready"},   32'(ready),   32'(exp_ready));
  endtask

  task automatic step(input string ctx);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ctx);
  endtask

  task automatic run(input int n, input string ctx);
    for (int i = 0; i < n; i++) step(ctx);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    soft_rst_req = 1'b0;
    cfg_we       = 1'b0;
    cfg_ch       = 4'd0;
    cfg_div      = '0;
    model_reset();

    // Power-on: reset held three cycles, then the staggered release.
    run(3, "por_hold");
    rst = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      step("por_seq");
      if (n == 15) check("por_c15_rst", 32'(rst_out), 32'hF);
      if (n == 16) check("por_c16_rst", 32'(rst_out), 32'hE);
      if (n == 20) check("por_c20_rst", 32'(rst_out), 32'hC);
      if (n == 24) check("por_c24_rst", 32'(rst_out), 32'h8);
      if (n == 28) check("por_c28_ready", 32'(ready), 32'h0);
      if (n == 28) check("por_c28_rst", 32'(rst_out), 32'h0);
      if (n == 29) check("por_c29_ready", 32'(ready), 32'h1);
    end

    // Divider write on channel 1.
    cfg_we = 1'b1; cfg_ch = 4'd1; cfg_div = 16'd3;
    step("cfg_ch1");
    cfg_we = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step("ch1_period");
      if (n == 4 || n == 8) check("ch1_tick_on", 32'(tick[1]), 32'h1);
      if (n == 5) check("ch1_tick_off", 32'(tick[1]), 32'h0);
    end

    // Soft reset pulse during RUN.
    soft_rst_req = 1'b1;
    step("soft_run");
    check("soft_run_rst", 32'(rst_out), 32'hF);
    soft_rst_req = 1'b0;
    run(45, "soft_run_seq");

    // Soft reset while releasing, after ch0 is out of reset.
    soft_rst_req = 1'b1; step("soft2");
    soft_rst_req = 1'b0; run(18, "pre_release");
    check("rel_ch0_out", 32'(rst_out), 32'hE);
    soft_rst_req = 1'b1; step("soft_release");
    check("soft_release_rst", 32'(rst_out), 32'hF);
    soft_rst_req = 1'b0; run(40, "resequence");

    // Out-of-range channel write, then a write coincident with soft reset.
    cfg_we = 1'b1; cfg_ch = 4'd7; cfg_div = 16'd5;
    step("cfg_ch7");
    cfg_we = 1'b0; run(10, "after_ch7");
    cfg_we = 1'b1; cfg_ch = 4'd2; cfg_div = 16'd2; soft_rst_req = 1'b1;
    step("cfg_soft");
    cfg_we = 1'b0; soft_rst_req = 1'b0;
    run(45, "cfg_soft_seq");

    // Randomized writes and soft resets.
    for (int n = 0; n < 400; n++) begin
      cfg_we       = ($urandom_range(0, 7) == 0);
      cfg_ch       = 4'($urandom_range(0, 7));
      cfg_div      = DIV_W'($urandom_range(0, 9));
      soft_rst_req = ($urandom_range(0, 63) == 0);
      if (($urandom_range(0, 3) == 0) && ($urandom_range(0, 1) == 0)) soft_rst_req = soft_rst_req | ($urandom_range(0, 15) == 0);
      step("rand");
    end
    cfg_we = 1'b0; soft_rst_req = 1'b0;
    run(40, "settle");

    // Asynchronous reset asserted between edges.
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    run(2, "async_hold");
    rst = 1'b0;
    run(40, "async_reseq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
